muldiv_unit: RTL

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits beside the Execute-stage ALU, accepts mult/multu/div/divu from the E-stage control, and runs them over multiple cycles. It raises `busy` to the hazard unit and serves mfhi/mflo/mthi/mtlo traffic. It replaces the single-cycle mult/div path carried in the controller pipeline registers.

---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply, divide stays iterative.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancel,
  input  logic             mthiW,
  input  logic             mtloW,
  input  logic [WIDTH-1:0] wdataW,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             op_signed, sgn_a, sgn_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [PW-1:0]    prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  // Signed ops run on magnitudes; signs are restored in FIX.
  assign op_signed = ~opE[0];
  assign sgn_a     = op_signed & srcaE[WIDTH-1];
  assign sgn_b     = op_signed & srcbE[WIDTH-1];
  assign abs_a     = sgn_a ? WIDTH'(~srcaE + WIDTH'(1)) : srcaE;
  assign abs_b     = sgn_b ? WIDTH'(~srcbE + WIDTH'(1)) : srcbE;

  // {acc,b} is the product shift register (mul) or remainder:quotient (div).
  assign mul_sum   = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign div_trial = {acc_q, b_q[WIDTH-1]} - {1'b0, a_q};

  assign prod      = {acc_q, b_q};
  assign prod_fix  = neg_q ? PW'(~prod + PW'(1)) : prod;
  assign q_fix     = neg_q ? WIDTH'(~b_q + WIDTH'(1)) : b_q;
  assign r_fix     = rneg_q ? WIDTH'(~acc_q + WIDTH'(1)) : acc_q;

`ifdef MULDIV_FAST_MUL_EN
  logic [PW-1:0] fast_prod;
  assign fast_prod = PW'(abs_a) * PW'(abs_b);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    if (mthiW) hi_d = wdataW;
    if (mtloW) lo_d = wdataW;
    unique case (state_q)
      IDLE: begin
        if (startE && !cancel) begin
          is_div_d = opE[1];
          neg_d    = sgn_a ^ sgn_b;
          rneg_d   = sgn_a;
          dz_d     = (srcbE == '0);
          acc_d    = '0;
          cnt_d    = CW'(WIDTH - 1);
          a_d      = opE[1] ? abs_b : abs_a;
          b_d      = opE[1] ? abs_a : abs_b;
          state_d  = CALC;
`ifdef MULDIV_FAST_MUL_EN
          if (!opE[1]) begin
            {acc_d, b_d} = fast_prod;
            state_d      = FIX;
          end
`endif
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            // Restoring step: keep the subtraction only if it did not borrow.
            if (!div_trial[WIDTH]) begin
              acc_d = div_trial[WIDTH-1:0];
              b_d   = {b_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = {acc_q[WIDTH-2:0], b_q[WIDTH-1]};
              b_d   = {b_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = mul_sum[WIDTH:1];
            b_d   = {mul_sum[0], b_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Divide by zero yields all-ones quotient; remainder equals dividend.
            lo_d = dz_q ? {WIDTH{1'b1}} : q_fix;
            hi_d = r_fix;
          end else begin
            lo_d = prod_fix[WIDTH-1:0];
            hi_d = prod_fix[PW-1:WIDTH];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
